// File: rtl/seg7_monitor.sv
// seg7_monitor: receive-side checker for a 7-segment animation driver.
// It samples the segment bus, rejects transient patterns with a stability
// filter, decodes the accepted glyph back to a hex digit, and measures the
// clock distance between successive accepted glyph changes.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   segments     segment bus, bit0=a .. bit6=g, active high
//   sample_en    sampling enable; when low, filter/decoder state freezes
//   digit        hex value of the accepted glyph (0 if not a hex glyph)
//   digit_valid  accepted glyph is one of the 16 hex glyphs
//   blank        accepted glyph is all segments off
//   unknown      accepted glyph is neither a hex glyph nor blank
//   change_pulse one-cycle strobe after each newly accepted glyph
//   change_count accepted-change counter, wraps modulo 256
//   period       cycles between the last two accept edges (saturating)
//   period_valid at least two accepts since reset
module seg7_monitor #(
  parameter int STABLE_CYCLES = 16,
  parameter int PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          segments,
  input  logic                sample_en,
  output logic [3:0]          digit,
  output logic                digit_valid,
  output logic                blank,
  output logic                unknown,
  output logic                change_pulse,
  output logic [7:0]          change_count,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  // IDLE: nothing accepted since reset (the first candidate counts here).
  // SETTLE: a candidate differs from the accepted glyph.
  // STABLE: the candidate equals the accepted glyph.
  typedef enum logic [1:0] {IDLE, SETTLE, STABLE} state_t;

  state_t              state, state_nxt;
  logic                acc_vld;
  logic [6:0]          cand, cand_nxt, accepted;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                reach, accept;
  logic [PERIOD_W-1:0] cyc_cnt, cyc_sat;
  logic [4:0]          dec;

  // Returns {hit, value}; hit=0 for non-hex glyphs.
  function automatic logic [4:0] decode(input logic [6:0] g);
    case (g)
      7'h3F: decode = 5'h10;  7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;  7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;  7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;  7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;  7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;  7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;  7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;  7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // Stability filter. A new pattern counts as sample 1 on the edge it
  // appears; reach marks the edge on which the run length hits the target.
  always_comb begin
    cand_nxt = cand;
    cnt_nxt  = cnt;
    reach    = 1'b0;
    if (sample_en) begin
      if (segments != cand) begin
        cand_nxt = segments;
        cnt_nxt  = CW'(1);
        reach    = (STABLE_CYCLES == 1);
      end else if (cnt < CNT_MAX) begin
        cnt_nxt = cnt + CW'(1);
        reach   = (cnt_nxt == CNT_MAX);
      end
    end
  end

  assign accept  = reach && (!acc_vld || cand_nxt != accepted);
  assign cyc_sat = (&cyc_cnt) ? cyc_cnt : cyc_cnt + PERIOD_W'(1);
  assign dec     = decode(cand_nxt);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = STABLE;
    else if (state != IDLE && sample_en)
      state_nxt = (cand_nxt == accepted) ? STABLE : SETTLE;
  end

  // FSM: outputs
  always_comb begin
    acc_vld = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand         <= '0;
      cnt          <= '0;
      accepted     <= '0;
      cyc_cnt      <= '0;
      digit        <= '0;
      digit_valid  <= 1'b0;
      blank        <= 1'b0;
      unknown      <= 1'b0;
      change_pulse <= 1'b0;
      change_count <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      cand         <= cand_nxt;
      cnt          <= cnt_nxt;
      change_pulse <= accept;
      cyc_cnt      <= accept ? '0 : cyc_sat;
      if (accept) begin
        accepted     <= cand_nxt;
        digit        <= dec[3:0];
        digit_valid  <= dec[4];
        blank        <= (cand_nxt == 7'h00);
        unknown      <= !dec[4] && (cand_nxt != 7'h00);
        change_count <= change_count + 8'd1;
        // The first accept only starts the measurement.
        period       <= cyc_sat;
        period_valid <= acc_vld;
      end
    end
  end

endmodule
